// File: rtl/int_arbiter_if.sv
// int_arbiter_if: request/ack/level bundle between the interrupt arbiter and the 8051 core side
interface int_arbiter_if;
   logic [4:0]  SRC_REQ;
   logic [7:0]  IE;
   logic [4:0]  IP;
   logic [1:0]  IT;
   logic        INST_BOUNDARY;
   logic        INT_ACK;
   logic        RETI_EXEC;
   logic        INT_REQ;
   logic [15:0] INT_VECTOR;
   logic [1:0]  INT_LEVEL;
   logic [4:0]  INT_SRC_CLR;
   modport master (
      output SRC_REQ, IE, IP, IT, INST_BOUNDARY, INT_ACK, RETI_EXEC,
      input  INT_REQ, INT_VECTOR, INT_LEVEL, INT_SRC_CLR
   );
   modport slave (
      input  SRC_REQ, IE, IP, IT, INST_BOUNDARY, INT_ACK, RETI_EXEC,
      output INT_REQ, INT_VECTOR, INT_LEVEL, INT_SRC_CLR
   );
endinterface

// File: rtl/int_arbiter.sv
// int_arbiter: 8051 interrupt priority resolver with frozen vector request and in-service level tracking
module int_arbiter (
   input logic          CLK,
   input logic          RST,
   int_arbiter_if.slave bus
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_nx;
   logic [4:0] pend, hi, lo, cand, clr_mask, clr;
   logic [2:0] win_idx, gidx;
   logic [15:0] vector;
   logic high_act, low_act, block, glvl, win_hi, eligible, grant, ack, h_ret, l_ret;

   function automatic logic [2:0] first(input logic [4:0] v);
      return v[0] ? 3'd0 : v[1] ? 3'd1 : v[2] ? 3'd2 : v[3] ? 3'd3 : 3'd4;
   endfunction

   always_comb begin
      hi = pend & bus.IP;
      lo = pend & ~bus.IP;
      win_hi = |hi;
      cand = win_hi ? hi : lo;
      win_idx = first(cand);
      // a blocked winner stalls everything below it rather than passing the grant down
      eligible = (|cand) & ~high_act & (win_hi | ~low_act);
      grant = state == IDLE && bus.INST_BOUNDARY && !bus.RETI_EXEC && !block && eligible;
      ack = state == REQ && bus.INT_ACK;
      h_ret = bus.RETI_EXEC ? 1'b0 : high_act;
      l_ret = bus.RETI_EXEC && !high_act ? 1'b0 : low_act;
      clr_mask = (5'b00001 << gidx) & {1'b0, 1'b1, bus.IT[1], 1'b1, bus.IT[0]};
      state_nx = grant ? REQ : ack ? IDLE : state;
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else state <= state_nx;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pend <= '0;
         high_act <= 1'b0;
         low_act <= 1'b0;
         block <= 1'b0;
         clr <= '0;
         vector <= '0;
         glvl <= 1'b0;
         gidx <= '0;
      end else begin
         pend <= bus.SRC_REQ & bus.IE[4:0] & {5{bus.IE[7]}};
         high_act <= h_ret | (ack & glvl);
         low_act <= l_ret | (ack & ~glvl);
         block <= bus.RETI_EXEC | (block & ~bus.INST_BOUNDARY);
         clr <= ack ? clr_mask : '0;
         if (grant) begin
            vector <= {10'd0, win_idx, 3'b011};
            glvl <= win_hi;
            gidx <= win_idx;
         end
      end
   end

   assign bus.INT_REQ = state == REQ;
   assign bus.INT_VECTOR = vector;
   assign bus.INT_LEVEL = {high_act, high_act | low_act};
   assign bus.INT_SRC_CLR = clr;
endmodule

// File: doc/int_arbiter.md
# int_arbiter

Interrupt controller for the 8051 core and the request side of the instruction-extension path. It samples the five standard interrupt sources, resolves priority against IE/IP, and raises `INT_REQ` with a frozen vector address. It tracks the in-service priority levels and reports them on `INT_LEVEL`; the instruction-extension encoder consumes `INT_REQ` and `INT_LEVEL`. The core returns `INT_ACK` when the injected vector call executes and `RETI_EXEC` when the service routine returns.

## Interface
No parameters.
- `CLK`  in  1  system clock; all state on rising edge
- `RST`  in  1  synchronous reset, active-high
- `SRC_REQ`  in  5  raw flags, bit0..4 = IE0, TF0, IE1, TF1, RI|TI
- `IE`  in  8  IE SFR; bit7 = EA, bits4:0 = per-source enables
- `IP`  in  5  IP SFR bits4:0; 1 = high priority for that source
- `IT`  in  2  TCON IT0, IT1; 1 = edge-triggered external source
- `INST_BOUNDARY`  in  1  one-cycle strobe at each instruction fetch boundary
- `INT_ACK`  in  1  one-cycle pulse; core has started the vector call
- `RETI_EXEC`  in  1  one-cycle pulse; RETI executed
- `INT_REQ`  out  1  interrupt request to the instruction-extension encoder
- `INT_VECTOR`  out  16  vector address of the granted source
- `INT_LEVEL`  out  2  in-service level: 00 none, 01 low, 11 high (10 never driven)
- `INT_SRC_CLR`  out  5  one-cycle clear pulse for hardware-cleared flags

## Operation
- **PEND register:** `PEND <= SRC_REQ & IE[4:0] & {5{IE[7]}}`, updated every cycle.
- **Arbitration:** combinational, on PEND.
  - A high-priority source beats a low-priority one.
  - Within the same level, fixed order IE0 > TF0 > IE1 > TF1 > SER.
- **Eligibility:**
  - A high-level winner is eligible when `INT_LEVEL != 11`.
  - A low-level winner is eligible only when `INT_LEVEL == 00`.
  - An ineligible winner does not let a lower candidate through.
- **FSM states:** IDLE, REQ.
  - **IDLE → REQ:** occurs on `INST_BOUNDARY` when an eligible winner exists and BLOCK = 0. On that edge:
    - Latch `INT_VECTOR`: 0x0003, 0x000B, 0x0013, 0x001B, 0x0023 for sources 0..4.
    - Latch the winner's level (GLVL) and index.
    - Set `INT_REQ` = 1.
  - **REQ:** `INT_REQ` and `INT_VECTOR` are held frozen. Changes to PEND, IE or IP are ignored; a granted request is never cancelled.
  - **REQ → IDLE:** on `INT_ACK`. On that edge:
    - `INT_REQ` = 0.
    - Set HIGH_ACT if GLVL is high, otherwise LOW_ACT.
    - Pulse `INT_SRC_CLR[idx]` for one cycle, where idx is 0 with IT0 = 1, 1 always, 2 with IT1 = 1, or 3 always. Serial (idx 4) is never cleared.
  - `INT_ACK` in IDLE is ignored: no state change, no pulse.
- **Level flags:**
  - `INT_LEVEL = {HIGH_ACT, HIGH_ACT|LOW_ACT}`.
  - `RETI_EXEC` clears HIGH_ACT if it is set; otherwise it clears LOW_ACT; with neither set it has no effect.
- **BLOCK flag:** set by `RETI_EXEC`, cleared at the next `INST_BOUNDARY`. The IDLE→REQ transition is suppressed at that boundary, so at least one instruction executes after RETI.
- **Simultaneous events:**
  - `RETI_EXEC` with `INT_ACK` in the same cycle: RETI's clear is applied first, then the ACK's set.
  - `RETI_EXEC` with `INST_BOUNDARY` in the same cycle: the boundary is blocked.

## Timing
- **Reset values:** `INT_REQ` 0, `INT_VECTOR` 0x0000, `INT_LEVEL` 00, `INT_SRC_CLR` 00000. Internal: PEND 0, HIGH_ACT 0, LOW_ACT 0, BLOCK 0, state IDLE.
- `RST` mid-REQ abandons the request with no clear pulse.
- `SRC_REQ` to PEND: 1 cycle.
- `INST_BOUNDARY` in cycle N, with the PEND value present in N, gives `INT_REQ` high in N+1. Minimum source-to-request latency is 2 cycles.
- `INT_ACK` in cycle N gives, in N+1: `INT_REQ` low, `INT_LEVEL` updated, and the `INT_SRC_CLR` pulse, lasting exactly one cycle.
- `RETI_EXEC` in N: `INT_LEVEL` updated in N+1.
- Earliest re-request after ACK: the next `INST_BOUNDARY` at or after N+1, evaluated against the updated `INT_LEVEL`.

## Test plan
- **Single source:** EA = 1, EX0 = 1, IT0 = 1, IE0 raised, boundary strobe.
  - `INT_REQ` = 1 and `INT_VECTOR` = 0x0003 two cycles after the flag.
  - After ACK: `INT_LEVEL` = 01 and `INT_SRC_CLR` = 00001 for one cycle.
- **Priority order:** TF1 (IP = 1) and IE0 (IP = 0) pending together → vector 0x001B, then `INT_LEVEL` = 11 after ACK. IE0 is held off until a RETI, then served at 0x0003 on the second boundary after RETI.
- **Nesting:**
  - Low TF0 in service (`INT_LEVEL` 01): a high IE1 request gives vector 0x0013 and `INT_LEVEL` 11.
  - A low SER request is not granted.
  - RETI → 01, RETI → 00.
- **Serial and level-triggered sources:** RI with ES = 1 → vector 0x0023 and `INT_SRC_CLR` stays 00000 after ACK. IE1 with IT1 = 0 → no clear pulse.
- **Frozen request:** clear EA while in REQ → `INT_REQ` stays 1 and the vector is unchanged until ACK. ACK in IDLE → no change.
- **Reset during REQ:** all outputs return to reset values next cycle; simultaneous RETI + ACK with `INT_LEVEL` 01 and a high grant → `INT_LEVEL` 11.
